// File: rtl/pisc_multi_if.sv
// pisc_multi_if: shared config write port, per-channel enables and channel outputs of the blinker
interface pisc_multi_if #(parameter int CHANNELS = 4, parameter int CNT_W = 16, parameter int CH_W = 2);
    logic                cfg_we;
    logic [CH_W-1:0]     cfg_ch;
    logic [CNT_W-1:0]    cfg_half;
    logic [1:0]          cfg_mode;
    logic [7:0]          cfg_count;
    logic [CHANNELS-1:0] en;
    logic [CHANNELS-1:0] s;
    logic [CHANNELS-1:0] busy;
    logic [CHANNELS-1:0] done;
    modport master (output cfg_we, cfg_ch, cfg_half, cfg_mode, cfg_count, en, input s, busy, done);
    modport slave (input cfg_we, cfg_ch, cfg_half, cfg_mode, cfg_count, en, output s, busy, done);
endinterface

// File: rtl/pisc_multi.sv
// pisc_multi: multi-channel programmable blinker with off, continuous, burst and one-shot modes
module pisc_multi #(parameter int CHANNELS = 4, parameter int CNT_W = 16, parameter int CH_W = 2) (
    input logic clock,
    input logic r,
    pisc_multi_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, FINISHED} state_t;
    localparam logic [1:0] OFF = 2'b00, BURST = 2'b10, ONESHOT = 2'b11;
    state_t st_q [CHANNELS];
    state_t st_d [CHANNELS];
    logic [CHANNELS-1:0][CNT_W-1:0] half_q, half_d, cnt_q, cnt_d;
    logic [CHANNELS-1:0][1:0] mode_q, mode_d;
    logic [CHANNELS-1:0][7:0] count_q, count_d, pc_q, pc_d;
    logic [CHANNELS-1:0] en_q, s_q, s_d, busy_q, busy_d, done_q, done_d, wr, wrap, fin;
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            st_d[i] = st_q[i];
            half_d[i] = half_q[i];
            mode_d[i] = mode_q[i];
            count_d[i] = count_q[i];
            cnt_d[i] = cnt_q[i];
            pc_d[i] = pc_q[i];
            s_d[i] = s_q[i];
            busy_d[i] = busy_q[i];
            done_d[i] = 1'b0;
            wr[i] = bus.cfg_we && int'(bus.cfg_ch) == i;
            wrap[i] = cnt_q[i] == half_q[i] - CNT_W'(1);
            // count==0 encodes 256 pulses, hence the 9-bit compare
            fin[i] = s_q[i] && wrap[i] && (mode_q[i] == ONESHOT ||
                     (mode_q[i] == BURST && {1'b0, pc_q[i]} + 9'd1 == {count_q[i] == 8'd0, count_q[i]}));
            if (wr[i]) begin
                half_d[i] = bus.cfg_half == '0 ? CNT_W'(1) : bus.cfg_half;
                mode_d[i] = bus.cfg_mode;
                count_d[i] = bus.cfg_count;
            end
            if (!bus.en[i]) begin
                st_d[i] = IDLE;
                s_d[i] = 1'b0;
                busy_d[i] = 1'b0;
                cnt_d[i] = '0;
                pc_d[i] = '0;
            end else if (!en_q[i] || wr[i]) begin
                st_d[i] = mode_d[i] != OFF ? RUN : IDLE;
                s_d[i] = mode_d[i] != OFF;
                busy_d[i] = mode_d[i] != OFF;
                cnt_d[i] = '0;
                pc_d[i] = '0;
            end else if (st_q[i] == RUN) begin
                cnt_d[i] = wrap[i] ? '0 : cnt_q[i] + CNT_W'(1);
                s_d[i] = wrap[i] ? ~s_q[i] : s_q[i];
                pc_d[i] = wrap[i] && s_q[i] ? pc_q[i] + 8'd1 : pc_q[i];
                if (fin[i]) begin
                    st_d[i] = FINISHED;
                    busy_d[i] = 1'b0;
                    done_d[i] = 1'b1;
                end
            end else if (st_q[i] == FINISHED) begin
                s_d[i] = 1'b0;
            end
        end
    end
    always_ff @(posedge clock or posedge r) begin
        if (r) begin
            for (int i = 0; i < CHANNELS; i++) begin
                st_q[i] <= IDLE;
                half_q[i] <= CNT_W'(1);
                count_q[i] <= 8'd1;
            end
            mode_q <= '0;
            cnt_q <= '0;
            pc_q <= '0;
            en_q <= '0;
            s_q <= '0;
            busy_q <= '0;
            done_q <= '0;
        end else begin
            st_q <= st_d;
            half_q <= half_d;
            mode_q <= mode_d;
            count_q <= count_d;
            cnt_q <= cnt_d;
            pc_q <= pc_d;
            en_q <= bus.en;
            s_q <= s_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end
    assign bus.s = s_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
endmodule

// File: tb/tb_pisc_multi.sv
// tb_pisc_multi: table-driven and hand-sequenced checks of the multi-channel blinker
module tb_pisc_multi;
    localparam int CH = 4, CW = 16, HW = 3;
    localparam logic [1:0] OFF = 2'b00, CONT = 2'b01, BURST = 2'b10, ONESHOT = 2'b11;
    logic clock = 1'b0;
    logic r = 1'b1;
    int checks = 0;
    int failures = 0;
    typedef struct {
        logic [3:0] en;
        logic we;
        logic [2:0] ch;
        logic [15:0] half;
        logic [1:0] mode;
        logic [7:0] count;
        logic [3:0] s, busy, done;
    } vec_t;
    vec_t tv[$];
    pisc_multi_if #(.CHANNELS(CH), .CNT_W(CW), .CH_W(HW)) bus ();
    pisc_multi #(.CHANNELS(CH), .CNT_W(CW), .CH_W(HW)) dut (.clock(clock), .r(r), .bus(bus));
    always #5 clock = ~clock;
    function automatic vec_t mk(input logic [3:0] en, input logic we, input logic [2:0] ch, input logic [15:0] half,
                                input logic [1:0] mode, input logic [7:0] count, input logic [3:0] s, busy, done);
        vec_t v;
        v.en = en; v.we = we; v.ch = ch; v.half = half; v.mode = mode; v.count = count;
        v.s = s; v.busy = busy; v.done = done;
        return v;
    endfunction
    task automatic drive(input logic [3:0] en, input logic we, input logic [2:0] ch, input logic [15:0] half,
                         input logic [1:0] mode, input logic [7:0] count);
        bus.en = en; bus.cfg_we = we; bus.cfg_ch = ch; bus.cfg_half = half; bus.cfg_mode = mode; bus.cfg_count = count;
    endtask
    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask
    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", nm, act, exp);
        end
    endtask
    initial begin
        int n, highs;
        drive(4'b0000, 1'b0, 3'd0, 16'd1, OFF, 8'd1);
        repeat (2) @(negedge clock);
        chk("reset_s", int'(bus.s), 0);
        chk("reset_busy", int'(bus.busy), 0);
        chk("reset_done", int'(bus.done), 0);
        r = 1'b0;
        tick();
        // ch0 continuous half=3, abort mid high phase
        tv.push_back(mk(4'b0000, 1, 0, 3, CONT, 0, 4'b0000, 4'b0000, 4'b0000));
        for (int k = 0; k < 3; k++) tv.push_back(mk(4'b0001, 0, 0, 0, OFF, 0, 4'b0001, 4'b0001, 4'b0000));
        for (int k = 0; k < 3; k++) tv.push_back(mk(4'b0001, 0, 0, 0, OFF, 0, 4'b0000, 4'b0001, 4'b0000));
        tv.push_back(mk(4'b0001, 0, 0, 0, OFF, 0, 4'b0001, 4'b0001, 4'b0000));
        tv.push_back(mk(4'b0000, 0, 0, 0, OFF, 0, 4'b0000, 4'b0000, 4'b0000));
        tv.push_back(mk(4'b0000, 0, 0, 0, OFF, 0, 4'b0000, 4'b0000, 4'b0000));
        // ch1 burst half=2 count=3, config written on the same edge as en rises
        tv.push_back(mk(4'b0010, 1, 1, 2, BURST, 3, 4'b0010, 4'b0010, 4'b0000));
        tv.push_back(mk(4'b0010, 0, 0, 0, OFF, 0, 4'b0010, 4'b0010, 4'b0000));
        for (int p = 0; p < 2; p++) begin
            for (int k = 0; k < 2; k++) tv.push_back(mk(4'b0010, 0, 0, 0, OFF, 0, 4'b0000, 4'b0010, 4'b0000));
            for (int k = 0; k < 2; k++) tv.push_back(mk(4'b0010, 0, 0, 0, OFF, 0, 4'b0010, 4'b0010, 4'b0000));
        end
        tv.push_back(mk(4'b0010, 0, 0, 0, OFF, 0, 4'b0000, 4'b0000, 4'b0010));
        tv.push_back(mk(4'b0010, 0, 0, 0, OFF, 0, 4'b0000, 4'b0000, 4'b0000));
        tv.push_back(mk(4'b0010, 0, 0, 0, OFF, 0, 4'b0000, 4'b0000, 4'b0000));
        foreach (tv[i]) begin
            drive(tv[i].en, tv[i].we, tv[i].ch, tv[i].half, tv[i].mode, tv[i].count);
            tick();
            chk($sformatf("row%0d_s", i), int'(bus.s), int'(tv[i].s));
            chk($sformatf("row%0d_busy", i), int'(bus.busy), int'(tv[i].busy));
            chk($sformatf("row%0d_done", i), int'(bus.done), int'(tv[i].done));
        end
        // ch2 one-shot half=5, fired twice
        drive(4'b0000, 1, 2, 5, ONESHOT, 0);
        tick();
        for (int shot = 0; shot < 2; shot++) begin
            drive(4'b0100, 0, 0, 0, OFF, 0);
            for (int k = 0; k < 7; k++) begin
                tick();
                chk($sformatf("shot%0d_k%0d_s", shot, k), int'(bus.s[2]), int'(k < 5));
                chk($sformatf("shot%0d_k%0d_busy", shot, k), int'(bus.busy[2]), int'(k < 5));
                chk($sformatf("shot%0d_k%0d_done", shot, k), int'(bus.done[2]), int'(k == 5));
            end
            drive(4'b0000, 0, 0, 0, OFF, 0);
            tick();
        end
        // write to a nonexistent channel while ch0 runs
        for (int k = 0; k < 12; k++) begin
            drive(4'b0001, k == 4, 3'd5, 16'd1, OFF, 8'd9);
            tick();
            chk($sformatf("badch_k%0d_s", k), int'(bus.s[0]), int'((k % 6) < 3));
            chk($sformatf("badch_k%0d_busy", k), int'(bus.busy[0]), 1);
        end
        // asynchronous reset in the middle of a ch1 burst
        drive(4'b0000, 0, 0, 0, OFF, 0);
        tick();
        drive(4'b0010, 0, 0, 0, OFF, 0);
        tick();
        chk("rst_burst_started", int'(bus.s[1]), 1);
        tick();
        tick();
        #2 r = 1'b1;
        #1;
        chk("rst_async_s", int'(bus.s), 0);
        chk("rst_async_busy", int'(bus.busy), 0);
        chk("rst_async_done", int'(bus.done), 0);
        @(negedge clock);
        r = 1'b0;
        tick();
        chk("rst_mode_off_s", int'(bus.s[1]), 0);
        chk("rst_mode_off_busy", int'(bus.busy[1]), 0);
        // ch3 burst with half=0 and count=0: half 1, 256 pulses
        drive(4'b0000, 1, 3, 0, BURST, 0);
        tick();
        drive(4'b1000, 0, 0, 0, OFF, 0);
        n = 0;
        highs = 0;
        do begin
            tick();
            n++;
            if (bus.s[3]) highs++;
        end while (!bus.done[3] && n < 1000);
        chk("b256_done_seen", int'(bus.done[3]), 1);
        chk("b256_cycles", n, 512);
        chk("b256_pulses", highs, 256);
        chk("b256_busy_at_done", int'(bus.busy[3]), 0);
        tick();
        chk("b256_done_one_cycle", int'(bus.done[3]), 0);
        chk("b256_s_stays_low", int'(bus.s[3]), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pisc_multi.md
# pisc_multi

Multi-channel programmable blinker: each of `CHANNELS` independent channels drives a square-wave output `s[i]` with a run-time half-period. Each channel runs in one of four modes: off, continuous, burst of N pulses, or one-shot. It replaces the single fixed-rate toggler in status-LED and test-strobe paths. Channels are configured through a shared write port and started and stopped with per-channel level enables.

## Interface

Parameters:

- `CHANNELS`, 4: number of independent channels (≥1).
- `CNT_W`, 16: width of the half-period register and counter.
- `CH_W`, 2: width of `cfg_ch` (≥ clog2(CHANNELS), min 1).

Ports:

- `clock` in 1: single clock; all state on rising edge.
- `r` in 1: reset, asynchronous, active-high.
- `cfg_we` in 1: config write strobe, sampled on `clock` rising edge.
- `cfg_ch` in CH_W: target channel. Writes with `cfg_ch ≥ CHANNELS` are ignored.
- `cfg_half` in CNT_W: half-period in cycles. A value of 0 is stored as 1.
- `cfg_mode` in 2: mode select.
  - 00 OFF
  - 01 CONT
  - 10 BURST
  - 11 ONESHOT
- `cfg_count` in 8: pulse count for BURST. A value of 0 means 256.
- `en` in CHANNELS: per-channel run enable (level).
- `s` out CHANNELS: channel outputs (registered).
- `busy` out CHANNELS: channel active (registered).
- `done` out CHANNELS: one-cycle pulse on BURST or ONESHOT completion.

## Operation

- Per channel state:
  - registers `half`, `mode`, `count`
  - counter `cnt` (CNT_W)
  - pulse counter `pc` (8 bits)
  - FSM states: IDLE, RUN, FINISHED
  - `en_q` (`en` delayed one cycle)
- Reset (async, `r`=1): every channel goes to IDLE with:
  - `half`=1, `mode`=OFF, `count`=1, `cnt`=0, `pc`=0, `en_q`=0
  - `s`=0, `busy`=0, `done`=0
- Start event: `en[i]` rising (`en[i]`=1, `en_q[i]`=0), or a config write to channel i while `en[i]`=1.
  - On a start edge with `mode`≠OFF: FSM goes to RUN, `s`<=1, `cnt`<=0, `pc`<=0, `busy`<=1.
  - A start with `mode`=OFF goes to IDLE with `s`=0.
- RUN, each edge:
  - If `cnt`==`half`-1: `cnt`<=0 and `s` toggles. Otherwise `cnt`++.
  - As a result, `s` is high for exactly `half` cycles, then low for `half` cycles.
- Mode completion:
  - CONT: runs until `en` falls.
  - ONESHOT: at the first high→low toggle, `s`<=0, FSM goes to FINISHED, `busy`<=0, `done`<=1 for one cycle.
  - BURST: each high→low toggle increments `pc`. The toggle that makes `pc`==`count` (256 for `count`=0) goes to FINISHED with `busy`<=0 and a `done` pulse. `s` stays 0 from then on.
- FINISHED: holds `s`=0 while `en`=1. `en` falling moves the FSM to IDLE. A new rising `en`, or a config write while `en`=1, restarts the channel.
- `en[i]` low in any state: at the next edge the FSM goes to IDLE with `s`<=0, `busy`<=0, and no `done` pulse (abort).
- Config write:
  - Updates `half`, `mode` and `count` of `cfg_ch` at the edge.
  - If `en`=1, that same edge is a start using the new values; a running channel restarts from phase 0.
  - Writes to a channel never disturb other channels.
- Counter arithmetic is unsigned CNT_W. `cnt` never exceeds `half`-1, so it cannot wrap.

## Timing

- Latency from start edge to `s`=1: the outputs change at the same edge (registered), so `s` is visible one cycle after `en` is presented.
- Period = 2·`half` cycles; duty is exactly 50%.
- `done` is asserted in the cycle following the final falling toggle edge. It coincides with `s`=0 and `busy`=0, and lasts exactly 1 cycle.
- Simultaneous events:
  - `en` falling together with the final toggle: abort wins, so no `done`.
  - `cfg_we` together with an `en` rising edge: one start, using the new config.
  - `r` mid-burst: immediately `s`=0, `busy`=0, and the config returns to its defaults.
- `half`=1 in CONT: `s` toggles every cycle.

## Test plan

- Reset then write ch0 with `half`=3, CONT, then raise `en[0]` → `s[0]` pattern 1,1,1,0,0,0 repeating, and `busy[0]`=1 throughout.
- ch1 BURST, `half`=2, `count`=3, `en`=1 → exactly three 1,1,0,0 pulses, then `done[1]`=1 for one cycle with `busy[1]`=0, and `s[1]` stays 0 while `en` stays high.
- ch2 ONESHOT, `half`=5 → `s[2]` high for 5 cycles, then `done[2]` pulse. Lowering and re-raising `en[2]` repeats the shot.
- `cfg_half`=0 and `cfg_count`=0 on ch3 in BURST → behaves as `half`=1 with 256 pulses, and `done` arrives 512 cycles after start.
- Drop `en[0]` mid-high-phase in CONT → `s[0]`=0 and `busy[0]`=0 the next cycle, with no `done`. Pulse `r` during a ch1 burst → all outputs go to 0 asynchronously and `mode` reverts to OFF.
- Write `cfg_ch`=5 with `CHANNELS`=4 while all channels run → no channel changes phase or config.
